// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types, constants and saturation limits for the Booth multiplier datapath
package booth_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    localparam int PROD_W_DEFAULT = 8;

    function automatic int sat_limit_hi(input int width);
        int one;
        one = 1;
        return (one <<< (width - 1)) - 1;
    endfunction

    function automatic int sat_limit_lo(input int width);
        int one;
        one = 1;
        return -(one <<< (width - 1));
    endfunction

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - combinational signed accumulate-add with clamp to the accumulator range
module sat_add
    import booth_pkg::*;
#(
    parameter int ACC_W  = 12,
    parameter int PROD_W = PROD_W_DEFAULT
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [PROD_W-1:0] addend,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     ovf
);

    localparam int LIM_HI = sat_limit_hi(ACC_W);
    localparam int LIM_LO = sat_limit_lo(ACC_W);

    logic signed [ACC_W:0] wide;

    // One guard bit suffices: two in-range operands can never overflow ACC_W+1 bits.
    always_comb begin
        wide = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - PROD_W){addend[PROD_W-1]}}, addend};
        ovf  = wide[ACC_W] ^ wide[ACC_W-1];
        if (!ovf) begin
            sum = wide[ACC_W-1:0];
        end else if (wide[ACC_W]) begin
            sum = LIM_LO[ACC_W-1:0];
        end else begin
            sum = LIM_HI[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/booth_product_accumulator.sv
// rtl/booth_product_accumulator.sv - sums batches of signed products with saturation, valid/ready in and out
module booth_product_accumulator
    import booth_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEFAULT,
    parameter int ACC_W  = 12,
    parameter int BATCH  = 4,
    parameter int CNT_W  = $clog2(BATCH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] in_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_sum,
    output logic                     out_sat,
    output logic [CNT_W-1:0]         fill_count
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BATCH - 1);

    acc_state_t               state;
    logic signed [ACC_W-1:0]  acc;
    logic                     sat_sticky;
    logic signed [ACC_W-1:0]  add_sum;
    logic                     add_ovf;

    sat_add #(
        .ACC_W (ACC_W),
        .PROD_W(PROD_W)
    ) u_sat_add (
        .acc   (acc),
        .addend(in_product),
        .sum   (add_sum),
        .ovf   (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACCUM;
            acc        <= '0;
            fill_count <= '0;
            sat_sticky <= 1'b0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_sat    <= 1'b0;
            in_ready   <= 1'b1;
        end else if (clear) begin
            // Flush drops the partial batch but leaves the last delivered result visible.
            state      <= ACCUM;
            acc        <= '0;
            fill_count <= '0;
            sat_sticky <= 1'b0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc        <= add_sum;
                        fill_count <= fill_count + CNT_W'(1);
                        sat_sticky <= sat_sticky | add_ovf;
                        if (fill_count == LAST_IDX) begin
                            out_sum   <= add_sum;
                            out_sat   <= sat_sticky | add_ovf;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state      <= ACCUM;
                        acc        <= '0;
                        fill_count <= '0;
                        sat_sticky <= 1'b0;
                        out_valid  <= 1'b0;
                        in_ready   <= 1'b1;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// tb/tb_booth_product_accumulator.sv - randomized scoreboard bench over three parameterisations
module tb_booth_product_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic signed [7:0] in_product = '0;

    logic               rdy0, rdy1, rdy2;
    logic               ov0, ov1, ov2;
    logic signed [11:0] sum0;
    logic signed [7:0]  sum1;
    logic signed [11:0] sum2;
    logic               sat0, sat1, sat2;
    logic [2:0]         fc0, fc1;
    logic [0:0]         fc2;

    booth_product_accumulator dut_default (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy0),
        .in_product(in_product), .out_valid(ov0), .out_ready(out_ready),
        .out_sum(sum0), .out_sat(sat0), .fill_count(fc0)
    );

    booth_product_accumulator #(.ACC_W(8)) dut_narrow (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy1),
        .in_product(in_product), .out_valid(ov1), .out_ready(out_ready),
        .out_sum(sum1), .out_sat(sat1), .fill_count(fc1)
    );

    booth_product_accumulator #(.BATCH(1)) dut_single (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy2),
        .in_product(in_product), .out_valid(ov2), .out_ready(out_ready),
        .out_sum(sum2), .out_sat(sat2), .fill_count(fc2)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    int batch_of[3] = '{4, 4, 1};
    int accw_of[3]  = '{12, 8, 12};

    int o_rdy[3], o_val[3], o_sum[3], o_sat[3], o_fc[3];
    always_comb begin
        o_rdy[0] = int'(rdy0); o_val[0] = int'(ov0); o_sum[0] = int'(sum0); o_sat[0] = int'(sat0); o_fc[0] = int'(fc0);
        o_rdy[1] = int'(rdy1); o_val[1] = int'(ov1); o_sum[1] = int'(sum1); o_sat[1] = int'(sat1); o_fc[1] = int'(fc1);
        o_rdy[2] = int'(rdy2); o_val[2] = int'(ov2); o_sum[2] = int'(sum2); o_sat[2] = int'(sat2); o_fc[2] = int'(fc2);
    end

    // Reference: list of accepted products per batch, a pending-result flag and the last result.
    int q[3][$];
    int exp_valid[3];
    int exp_sum[3];
    int exp_sat[3];
    bit started = 1'b0;

    function automatic void close_batch(input int i);
        int s, sat, hi, lo;
        s = 0;
        sat = 0;
        hi = (1 << (accw_of[i] - 1)) - 1;
        lo = -(1 << (accw_of[i] - 1));
        for (int k = 0; k < q[i].size(); k++) begin
            s = s + q[i][k];
            if (s > hi) begin s = hi; sat = 1; end
            if (s < lo) begin s = lo; sat = 1; end
        end
        exp_sum[i] = s;
        exp_sat[i] = sat;
        exp_valid[i] = 1;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("d%0d_in_ready", i), o_rdy[i], exp_valid[i] ? 0 : 1);
                check($sformatf("d%0d_out_valid", i), o_val[i], exp_valid[i]);
                check($sformatf("d%0d_fill_count", i), o_fc[i], q[i].size());
                check($sformatf("d%0d_out_sum", i), o_sum[i], exp_sum[i]);
                check($sformatf("d%0d_out_sat", i), o_sat[i], exp_sat[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                q[i].delete();
                exp_valid[i] = 0;
                exp_sum[i] = 0;
                exp_sat[i] = 0;
            end else if (clear) begin
                q[i].delete();
                exp_valid[i] = 0;
            end else if (exp_valid[i] != 0) begin
                if (out_ready) begin
                    q[i].delete();
                    exp_valid[i] = 0;
                end
            end else if (in_valid) begin
                q[i].push_back(int'(in_product));
                if (q[i].size() == batch_of[i]) close_batch(i);
            end
        end
        if (rst) started = 1'b1;
    end

    task automatic cycle(input bit v, input int p, input bit r, input bit c, input bit rs);
        @(posedge clk);
        #1;
        in_valid   = v;
        in_product = 8'(p);
        out_ready  = r;
        clear      = c;
        rst        = rs;
    endtask

    int plist[];
    int rnd;

    initial begin
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 0);
        plist = '{6, -8, 15, 1};
        foreach (plist[k]) cycle(1, plist[k], 1, 0, 0);
        repeat (2) cycle(0, 0, 1, 0, 0);
        plist = '{64, 64, 64, 64, -56, -56, -56, -56, 1, 2, 3, 4};
        foreach (plist[k]) cycle(1, plist[k], 1, 0, 0);
        repeat (2) cycle(0, 0, 1, 0, 0);
        repeat (4) cycle(1, 10, 0, 0, 0);
        repeat (5) cycle(1, 9, 0, 0, 0);
        repeat (2) cycle(1, 9, 1, 0, 0);
        repeat (3) cycle(0, 0, 1, 0, 0);
        cycle(1, 0, 0, 1, 0);
        cycle(1, 3, 1, 0, 0);
        cycle(1, 5, 1, 0, 0);
        cycle(1, 7, 1, 1, 0);
        repeat (4) cycle(1, 1, 1, 0, 0);
        repeat (2) cycle(0, 0, 1, 0, 0);
        repeat (4) cycle(1, 5, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 0);
        cycle(1, -3, 1, 0, 0);
        cycle(1, 64, 1, 0, 0);
        cycle(1, 64, 1, 0, 0);
        repeat (2) cycle(0, 0, 1, 0, 0);
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 3))
                0: rnd = 127;
                1: rnd = -128;
                default: rnd = int'($urandom_range(0, 255)) - 128;
            endcase
            cycle($urandom_range(0, 3) != 0, rnd, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 40) == 0, $urandom_range(0, 300) == 0);
        end
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
